// File: rtl/sao_offset_div_seq.sv
// SAO initial-offset stage, sequential version.
// Computes round(|sum|/cnt) with a bit-serial restoring divider, clips it to the
// offset range, applies the sum's sign and the EO valley/peak constraint, then
// stores the result into per-component EO (16 entries) and BO (32 bands) tables.
module sao_offset_div_seq #(
  parameter int SUM_W  = 14,
  parameter int CNT_W  = 10,
  parameter int OFF_W  = 5,
  parameter int N_COMP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_comp,
  input  logic             in_mode,
  input  logic [4:0]       in_idx,
  output logic             out_valid,
  output logic [OFF_W-1:0] out_offset,
  output logic [1:0]       out_comp,
  output logic             out_mode,
  output logic [4:0]       out_idx,
  input  logic [1:0]       rd_comp,
  input  logic             rd_mode,
  input  logic [4:0]       rd_idx,
  output logic [OFF_W-1:0] rd_offset
);

  localparam int D_W  = SUM_W + 2;
  localparam int IT_W = $clog2(D_W);
  localparam logic [IT_W-1:0]  LAST_IT    = IT_W'(D_W - 1);
  localparam logic [OFF_W-1:0] OFFSET_MAX = {1'b0, {(OFF_W-1){1'b1}}};
  localparam logic [2:0]       N_COMP_L   = 3'(N_COMP);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic [D_W-1:0]     dvd_q, dvd_d;
  logic [CNT_W:0]     dvs_q, dvs_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [D_W-2:0]     quo_q, quo_d;
  logic [IT_W-1:0]    iter_q, iter_d;
  logic               neg_q, neg_d;
  logic [1:0]         comp_q, comp_d;
  logic               mode_q, mode_d;
  logic [4:0]         idx_q, idx_d;

  logic               out_valid_q, out_valid_d;
  logic [OFF_W-1:0]   out_offset_q, out_offset_d;
  logic [1:0]         out_comp_q, out_comp_d;
  logic               out_mode_q, out_mode_d;
  logic [4:0]         out_idx_q, out_idx_d;

  logic [OFF_W-1:0]   eo_tab_q [N_COMP][16];
  logic [OFF_W-1:0]   eo_tab_d [N_COMP][16];
  logic [OFF_W-1:0]   bo_tab_q [N_COMP][32];
  logic [OFF_W-1:0]   bo_tab_d [N_COMP][32];

  logic               accept;
  logic               in_zero;
  logic [SUM_W-1:0]   in_mag;
  logic [CNT_W+1:0]   trial;
  logic               trial_ge;
  logic [CNT_W:0]     rem_nxt;
  logic [D_W-1:0]     quo_nxt;
  logic               wr_en;
  logic               rd_ok;

  // Clip the quotient magnitude, re-apply the sign and zero any EO result whose
  // sign contradicts its category (valleys may not go negative, peaks not positive).
  function automatic logic [OFF_W-1:0] shape_offset(input logic [D_W-1:0] q,
                                                    input logic neg,
                                                    input logic mode,
                                                    input logic peak);
    logic [OFF_W-1:0] m;
    m = (|q[D_W-1:OFF_W-1]) ? OFFSET_MAX : {1'b0, q[OFF_W-2:0]};
    if (!mode && (neg != peak)) begin
      return '0;
    end
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign in_zero  = (in_sum == '0) || (in_cnt == '0);
  assign in_mag   = in_sum[SUM_W-1] ? (~in_sum + 1'b1) : in_sum;

  // One restoring-division step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    trial    = {rem_q, dvd_q[D_W-1]};
    trial_ge = (trial >= {1'b0, dvs_q});
    rem_nxt  = trial_ge ? (trial[CNT_W:0] - dvs_q) : trial[CNT_W:0];
    quo_nxt  = {quo_q, trial_ge};
  end

  // Next-state and registered-output logic for the IDLE/DIV/FIN sequencer.
  always_comb begin
    state_d      = state_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    iter_d       = iter_q;
    neg_d        = neg_q;
    comp_d       = comp_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    out_valid_d  = 1'b0;
    out_offset_d = out_offset_q;
    out_comp_d   = out_comp_q;
    out_mode_d   = out_mode_q;
    out_idx_d    = out_idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          neg_d  = in_sum[SUM_W-1];
          comp_d = in_comp;
          mode_d = in_mode;
          idx_d  = in_idx;
          dvd_d  = {1'b0, in_mag, 1'b0} + {{(D_W-CNT_W){1'b0}}, in_cnt};
          dvs_d  = {in_cnt, 1'b0};
          rem_d  = '0;
          quo_d  = '0;
          iter_d = '0;
          if (in_zero) begin
            state_d      = FIN;
            out_valid_d  = 1'b1;
            out_offset_d = '0;
            out_comp_d   = in_comp;
            out_mode_d   = in_mode;
            out_idx_d    = in_idx;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        dvd_d  = {dvd_q[D_W-2:0], 1'b0};
        rem_d  = rem_nxt;
        quo_d  = quo_nxt[D_W-2:0];
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_IT) begin
          state_d      = FIN;
          out_valid_d  = 1'b1;
          out_offset_d = shape_offset(quo_nxt, neg_q, mode_q, idx_q[1]);
          out_comp_d   = comp_q;
          out_mode_d   = mode_q;
          out_idx_d    = idx_q;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer, divider and output registers; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      iter_q       <= '0;
      neg_q        <= 1'b0;
      comp_q       <= '0;
      mode_q       <= 1'b0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_offset_q <= '0;
      out_comp_q   <= '0;
      out_mode_q   <= 1'b0;
      out_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      iter_q       <= iter_d;
      neg_q        <= neg_d;
      comp_q       <= comp_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_offset_q <= out_offset_d;
      out_comp_q   <= out_comp_d;
      out_mode_q   <= out_mode_d;
      out_idx_q    <= out_idx_d;
    end
  end

  assign wr_en = (state_q == FIN) && ({1'b0, out_comp_q} < N_COMP_L) &&
                 (out_mode_q || !out_idx_q[4]);

  // Table update: clear beats the FIN write, out-of-range addresses are dropped.
  always_comb begin
    eo_tab_d = eo_tab_q;
    bo_tab_d = bo_tab_q;
    if (clr) begin
      for (int c = 0; c < N_COMP; c++) begin
        for (int i = 0; i < 16; i++) eo_tab_d[c][i] = '0;
        for (int i = 0; i < 32; i++) bo_tab_d[c][i] = '0;
      end
    end else if (wr_en) begin
      if (out_mode_q) begin
        bo_tab_d[out_comp_q][out_idx_q] = out_offset_q;
      end else begin
        eo_tab_d[out_comp_q][out_idx_q[3:0]] = out_offset_q;
      end
    end
  end

  // Offset table storage, zeroed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_COMP; c++) begin
        for (int i = 0; i < 16; i++) eo_tab_q[c][i] <= '0;
        for (int i = 0; i < 32; i++) bo_tab_q[c][i] <= '0;
      end
    end else begin
      eo_tab_q <= eo_tab_d;
      bo_tab_q <= bo_tab_d;
    end
  end

  // Combinational read port; selects outside the tables read as zero.
  always_comb begin
    rd_ok     = ({1'b0, rd_comp} < N_COMP_L) && (rd_mode || !rd_idx[4]);
    rd_offset = '0;
    if (rd_ok) begin
      rd_offset = rd_mode ? bo_tab_q[rd_comp][rd_idx] : eo_tab_q[rd_comp][rd_idx[3:0]];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_offset = out_offset_q;
  assign out_comp   = out_comp_q;
  assign out_mode   = out_mode_q;
  assign out_idx    = out_idx_q;

endmodule
